// File: rtl/biriscv_fetch_pkg.sv
//==============================================================================
// Module      : biriscv_fetch_pkg
// Description : Shared fetch-packet type and constants for the fetch queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package biriscv_fetch_pkg;

    localparam int         c_LANES          = 2;
    localparam logic [2:0] c_SLOT0_OFFSET   = 3'b000;
    localparam logic [2:0] c_SLOT1_OFFSET   = 3'b100;
    localparam int         c_INFO_W_DEFAULT = 12;

    typedef struct packed {
        logic [31:0]                 pc;
        logic [63:0]                 data;
        logic [c_INFO_W_DEFAULT-1:0] info0;
        logic [c_INFO_W_DEFAULT-1:0] info1;
        logic                        valid0;
        logic                        valid1;
    } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/biriscv_fetch_queue_entry_ctl.sv
//==============================================================================
// Module      : biriscv_fetch_queue_entry_ctl
// Description : Lane valid masking for incoming packets, pop qualification and
//               head-entry retire detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module biriscv_fetch_queue_entry_ctl
    import biriscv_fetch_pkg::*;
(
    input  logic               i_pc_bit2,
    input  logic               i_pred0,
    input  logic               i_head_valid0,
    input  logic               i_head_valid1,
    input  logic               i_pop0,
    input  logic               i_pop1,
    input  logic               i_flush,
    output logic [c_LANES-1:0] o_push_valid,
    output logic [c_LANES-1:0] o_pop_ok,
    output logic [c_LANES-1:0] o_remain,
    output logic               o_retire
);

    logic [c_LANES-1:0] w_head_valid;
    logic [c_LANES-1:0] w_pop_req;

    // Odd-word target kills lane0; a taken prediction in lane0 kills lane1.
    assign o_push_valid = {~i_pred0, ~i_pc_bit2};

    assign w_head_valid = {i_head_valid1, i_head_valid0};
    assign w_pop_req    = {i_pop1, i_pop0};

    assign o_pop_ok = w_pop_req & w_head_valid & {c_LANES{~i_flush}};
    assign o_remain = w_head_valid & ~o_pop_ok;

    // Retire once the last live lane of the head has been consumed.
    assign o_retire = (|o_pop_ok) & ~(|o_remain);

endmodule

`default_nettype wire

// File: rtl/biriscv_fetch_queue.sv
//==============================================================================
// Module      : biriscv_fetch_queue
// Description : Dual-lane fetch packet queue feeding the dual-issue decoder.
//               Optional FETCH_QUEUE_BYPASS_EN presents an incoming packet
//               combinationally when the queue is empty.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module biriscv_fetch_queue
    import biriscv_fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int INFO_W = c_INFO_W_DEFAULT
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [31:0]       pc_in_i,
    input  logic [1:0]        pred_in_i,
    input  logic [63:0]       data_in_i,
    input  logic [INFO_W-1:0] info0_in_i,
    input  logic [INFO_W-1:0] info1_in_i,
    output logic              accept_o,
    output logic              valid0_o,
    output logic              valid1_o,
    output logic [31:0]       pc0_o,
    output logic [31:0]       pc1_o,
    output logic [31:0]       data0_o,
    output logic [31:0]       data1_o,
    output logic [INFO_W-1:0] info0_o,
    output logic [INFO_W-1:0] info1_o,
    input  logic              pop0_i,
    input  logic              pop1_i,
    output logic [ADDR_W:0]   count_o,
    output logic              almost_full_o
);

    logic [ADDR_W:0]    r_count;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [28:0]        r_pc    [DEPTH];
    logic [63:0]        r_data  [DEPTH];
    logic [INFO_W-1:0]  r_info0 [DEPTH];
    logic [INFO_W-1:0]  r_info1 [DEPTH];
    logic [DEPTH-1:0]   r_valid0;
    logic [DEPTH-1:0]   r_valid1;

    logic               w_not_empty;
    logic [c_LANES-1:0] w_push_valid;
    logic [c_LANES-1:0] w_pop_ok;
    logic [c_LANES-1:0] w_remain;
    logic [c_LANES-1:0] w_wr_valid;
    logic               w_retire;
    logic               w_push_req;
    logic               w_bypass;
    logic               w_wr_en;
    logic               w_head_retire;
    logic               w_head_v0;
    logic               w_head_v1;
    logic [28:0]        w_head_pc;
    logic [63:0]        w_head_data;
    logic [INFO_W-1:0]  w_head_info0;
    logic [INFO_W-1:0]  w_head_info1;
    logic               w_unused_ok;

    // PC bits [1:0] and the lane1 prediction never affect queue state.
    assign w_unused_ok = ^{pc_in_i[1:0], pred_in_i[1]};

    assign w_not_empty = (r_count != '0);
    assign accept_o    = (r_count != (ADDR_W+1)'(DEPTH));
    assign w_push_req  = push_i & accept_o & ~flush_i & (|w_push_valid);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass     = w_push_req & ~w_not_empty;
    assign w_head_v0    = w_bypass ? w_push_valid[0] : (w_not_empty & r_valid0[r_rd_ptr]);
    assign w_head_v1    = w_bypass ? w_push_valid[1] : (w_not_empty & r_valid1[r_rd_ptr]);
    assign w_head_pc    = w_bypass ? pc_in_i[31:3]   : r_pc[r_rd_ptr];
    assign w_head_data  = w_bypass ? data_in_i       : r_data[r_rd_ptr];
    assign w_head_info0 = w_bypass ? info0_in_i      : r_info0[r_rd_ptr];
    assign w_head_info1 = w_bypass ? info1_in_i      : r_info1[r_rd_ptr];
`else
    assign w_bypass     = 1'b0;
    assign w_head_v0    = w_not_empty & r_valid0[r_rd_ptr];
    assign w_head_v1    = w_not_empty & r_valid1[r_rd_ptr];
    assign w_head_pc    = r_pc[r_rd_ptr];
    assign w_head_data  = r_data[r_rd_ptr];
    assign w_head_info0 = r_info0[r_rd_ptr];
    assign w_head_info1 = r_info1[r_rd_ptr];
`endif

    biriscv_fetch_queue_entry_ctl u_entry_ctl (
        .i_pc_bit2     (pc_in_i[2]),
        .i_pred0       (pred_in_i[0]),
        .i_head_valid0 (w_head_v0),
        .i_head_valid1 (w_head_v1),
        .i_pop0        (pop0_i),
        .i_pop1        (pop1_i),
        .i_flush       (flush_i),
        .o_push_valid  (w_push_valid),
        .o_pop_ok      (w_pop_ok),
        .o_remain      (w_remain),
        .o_retire      (w_retire)
    );

    // A bypassed packet that is fully consumed is never written; a partly
    // consumed one is stored with its popped lane already cleared.
    assign w_wr_en       = w_push_req & ~(w_bypass & w_retire);
    assign w_wr_valid    = w_bypass ? w_remain : w_push_valid;
    assign w_head_retire = w_retire & ~w_bypass;

    assign valid0_o      = w_head_v0;
    assign valid1_o      = w_head_v1;
    assign pc0_o         = {w_head_pc, c_SLOT0_OFFSET};
    assign pc1_o         = {w_head_pc, c_SLOT1_OFFSET};
    assign data0_o       = w_head_data[31:0];
    assign data1_o       = w_head_data[63:32];
    assign info0_o       = w_head_info0;
    assign info1_o       = w_head_info1;
    assign count_o       = r_count;
    assign almost_full_o = (r_count >= (ADDR_W+1)'(DEPTH-1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_valid0 <= '0;
            r_valid1 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_data[i]  <= '0;
                r_info0[i] <= '0;
                r_info1[i] <= '0;
            end
        end else if (flush_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_valid0 <= '0;
            r_valid1 <= '0;
        end else begin
            if (!w_bypass) begin
                if (w_pop_ok[0]) r_valid0[r_rd_ptr] <= 1'b0;
                if (w_pop_ok[1]) r_valid1[r_rd_ptr] <= 1'b0;
            end
            if (w_wr_en) begin
                r_pc[r_wr_ptr]     <= pc_in_i[31:3];
                r_data[r_wr_ptr]   <= data_in_i;
                r_info0[r_wr_ptr]  <= info0_in_i;
                r_info1[r_wr_ptr]  <= info1_in_i;
                r_valid0[r_wr_ptr] <= w_wr_valid[0];
                r_valid1[r_wr_ptr] <= w_wr_valid[1];
                r_wr_ptr           <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_head_retire) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_wr_en, w_head_retire})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_biriscv_fetch_queue.sv
//==============================================================================
// Module      : tb_biriscv_fetch_queue
// Description : Directed self-checking bench for biriscv_fetch_queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_biriscv_fetch_queue;
    import biriscv_fetch_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int INFO_W = c_INFO_W_DEFAULT;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              push;
    logic [31:0]       pc_in;
    logic [1:0]        pred_in;
    logic [63:0]       data_in;
    logic [INFO_W-1:0] info0_in;
    logic [INFO_W-1:0] info1_in;
    logic              accept;
    logic              valid0;
    logic              valid1;
    logic [31:0]       pc0;
    logic [31:0]       pc1;
    logic [31:0]       data0;
    logic [31:0]       data1;
    logic [INFO_W-1:0] info0;
    logic [INFO_W-1:0] info1;
    logic              pop0;
    logic              pop1;
    logic [ADDR_W:0]   count;
    logic              almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    biriscv_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INFO_W(INFO_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .push_i       (push),
        .pc_in_i      (pc_in),
        .pred_in_i    (pred_in),
        .data_in_i    (data_in),
        .info0_in_i   (info0_in),
        .info1_in_i   (info1_in),
        .accept_o     (accept),
        .valid0_o     (valid0),
        .valid1_o     (valid1),
        .pc0_o        (pc0),
        .pc1_o        (pc1),
        .data0_o      (data0),
        .data1_o      (data1),
        .info0_o      (info0),
        .info1_o      (info1),
        .pop0_i       (pop0),
        .pop1_i       (pop1),
        .count_o      (count),
        .almost_full_o(almost_full)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compares every head output against an expected packet.
    task automatic chk_head(input string tag, input fetch_pkt_t e);
        chk_eq({tag, ".valid0"}, 64'(valid0), 64'(e.valid0));
        chk_eq({tag, ".valid1"}, 64'(valid1), 64'(e.valid1));
        chk_eq({tag, ".pc0"},    64'(pc0),    64'({e.pc[31:3], 3'b000}));
        chk_eq({tag, ".pc1"},    64'(pc1),    64'({e.pc[31:3], 3'b100}));
        chk_eq({tag, ".data0"},  64'(data0),  64'(e.data[31:0]));
        chk_eq({tag, ".data1"},  64'(data1),  64'(e.data[63:32]));
        chk_eq({tag, ".info0"},  64'(info0),  64'(e.info0));
        chk_eq({tag, ".info1"},  64'(info1),  64'(e.info1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; push = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
        pc_in = '0; pred_in = '0; data_in = '0; info0_in = '0; info1_in = '0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [63:0] data, input logic [1:0] pred);
        push = 1'b1; pc_in = pc; data_in = data; pred_in = pred;
        info0_in = pc[15:4]; info1_in = ~pc[15:4];
    endtask

    task automatic do_push(input logic [31:0] pc, input logic [63:0] data, input logic [1:0] pred);
        set_push(pc, data, pred);
        step();
        push = 1'b0;
    endtask

    task automatic do_pop(input logic p0, input logic p1);
        pop0 = p0; pop1 = p1;
        step();
        pop0 = 1'b0; pop1 = 1'b0;
    endtask

    function automatic fetch_pkt_t mk(input logic [31:0] pc, input logic [63:0] data,
                                      input logic v0, input logic v1);
        fetch_pkt_t p;
        p.pc = pc; p.data = data; p.info0 = pc[15:4]; p.info1 = ~pc[15:4];
        p.valid0 = v0; p.valid1 = v1;
        return p;
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk_eq("rst.valid0", 64'(valid0), 64'd0);
        chk_eq("rst.valid1", 64'(valid1), 64'd0);
        chk_eq("rst.count",  64'(count),  64'd0);
        chk_eq("rst.accept", 64'(accept), 64'd1);
        chk_eq("rst.afull",  64'(almost_full), 64'd0);
        chk_eq("rst.pc0",    64'(pc0),    64'd0);
        chk_eq("rst.data0",  64'(data0),  64'd0);

        // Aligned packet, both lanes live
        do_push(32'h1000, 64'h00000013_00100093, 2'b00);
        chk_head("p1", mk(32'h1000, 64'h00000013_00100093, 1'b1, 1'b1));
        chk_eq("p1.count", 64'(count), 64'd1);
        do_pop(1'b1, 1'b1);
        chk_eq("p1.pop.count",  64'(count),  64'd0);
        chk_eq("p1.pop.valid0", 64'(valid0), 64'd0);

        // Odd-word target: lane0 masked
        do_push(32'h2004, 64'hAAAA0001_BBBB0002, 2'b00);
        chk_head("p2", mk(32'h2000, 64'hAAAA0001_BBBB0002, 1'b0, 1'b1));
        do_pop(1'b0, 1'b1);
        chk_eq("p2.pop.count", 64'(count), 64'd0);

        // Predicted-taken lane0: lane1 masked, pop0 alone retires
        do_push(32'h2010, 64'h11112222_33334444, 2'b01);
        chk_head("p3", mk(32'h2010, 64'h11112222_33334444, 1'b1, 1'b0));
        do_pop(1'b1, 1'b0);
        chk_eq("p3.pop.count", 64'(count), 64'd0);

        // Both lanes masked: nothing stored, still accepting
        set_push(32'h3004, 64'h5, 2'b01);
        #1;
        chk_eq("p4.accept", 64'(accept), 64'd1);
        step();
        push = 1'b0;
        chk_eq("p4.count",  64'(count),  64'd0);
        chk_eq("p4.valid0", 64'(valid0), 64'd0);
        chk_eq("p4.valid1", 64'(valid1), 64'd0);

        // Fill to DEPTH
        for (int i = 0; i < 3; i++) do_push(32'h4000 + 32'(i*8), {32'(i), 32'(i+100)}, 2'b00);
        chk_eq("fill3.count", 64'(count), 64'd3);
        chk_eq("fill3.afull", 64'(almost_full), 64'd1);
        chk_eq("fill3.accept", 64'(accept), 64'd1);
        do_push(32'h4018, {32'd3, 32'd103}, 2'b00);
        chk_eq("fill4.count", 64'(count), 64'd4);
        chk_eq("fill4.accept", 64'(accept), 64'd0);
        do_push(32'h5000, 64'h0, 2'b00);
        chk_eq("full.push.count", 64'(count), 64'd4);
        chk_head("full.head", mk(32'h4000, {32'd0, 32'd100}, 1'b1, 1'b1));

        // Split pops on the head, then lane1 later retires it
        do_pop(1'b1, 1'b0);
        chk_eq("split.count", 64'(count), 64'd4);
        chk_eq("split.valid0", 64'(valid0), 64'd0);
        chk_eq("split.valid1", 64'(valid1), 64'd1);
        do_pop(1'b0, 1'b1);
        chk_eq("split.retire.count", 64'(count), 64'd3);
        chk_head("head2", mk(32'h4008, {32'd1, 32'd101}, 1'b1, 1'b1));
        do_pop(1'b1, 1'b1);
        chk_eq("retire3.count", 64'(count), 64'd2);

        // Push and retire in the same cycle at count=2
        set_push(32'h4020, {32'd4, 32'd104}, 2'b00);
        pop0 = 1'b1; pop1 = 1'b1;
        step();
        idle_inputs();
        chk_eq("pushpop.count", 64'(count), 64'd2);
        chk_head("pushpop.head", mk(32'h4018, {32'd3, 32'd103}, 1'b1, 1'b1));
        do_pop(1'b1, 1'b1);
        chk_head("tail.head", mk(32'h4020, {32'd4, 32'd104}, 1'b1, 1'b1));
        do_pop(1'b1, 1'b1);
        chk_eq("wrap.count", 64'(count), 64'd0);
        do_push(32'h6000, 64'h66666666_77777777, 2'b00);
        chk_head("wrap.head", mk(32'h6000, 64'h66666666_77777777, 1'b1, 1'b1));
        chk_eq("wrap.count1", 64'(count), 64'd1);
        do_pop(1'b1, 1'b1);

        // Flush with concurrent push
        do_push(32'h7000, 64'h70, 2'b00);
        do_push(32'h7008, 64'h78, 2'b00);
        do_push(32'h7010, 64'h80, 2'b00);
        do_pop(1'b1, 1'b0);
        flush = 1'b1;
        set_push(32'h8000, 64'h88, 2'b00);
        step();
        idle_inputs();
        chk_eq("flush.count",  64'(count),  64'd0);
        chk_eq("flush.valid0", 64'(valid0), 64'd0);
        chk_eq("flush.valid1", 64'(valid1), 64'd0);
        chk_eq("flush.accept", 64'(accept), 64'd1);
        do_push(32'h9000, 64'h99990000_99991111, 2'b01);
        chk_head("postflush", mk(32'h9000, 64'h99990000_99991111, 1'b1, 1'b0));
        chk_eq("postflush.count", 64'(count), 64'd1);
        do_pop(1'b1, 1'b0);
        chk_eq("postflush.drain", 64'(count), 64'd0);

        // Reset mid-operation drops entries
        do_push(32'hC000, 64'hC, 2'b00);
        do_push(32'hC008, 64'hD, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("midrst.count",  64'(count),  64'd0);
        chk_eq("midrst.valid0", 64'(valid0), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        set_push(32'hA000, 64'hA1A1A1A1_A0A0A0A0, 2'b00);
        pop0 = 1'b1; pop1 = 1'b1;
        #1;
        chk_head("byp.full", mk(32'hA000, 64'hA1A1A1A1_A0A0A0A0, 1'b1, 1'b1));
        step();
        idle_inputs();
        chk_eq("byp.full.count", 64'(count), 64'd0);
        set_push(32'hB000, 64'hB1B1B1B1_B0B0B0B0, 2'b00);
        pop0 = 1'b1;
        #1;
        chk_eq("byp.part.valid0", 64'(valid0), 64'd1);
        step();
        idle_inputs();
        chk_eq("byp.part.count", 64'(count), 64'd1);
        chk_head("byp.part", mk(32'hB000, 64'hB1B1B1B1_B0B0B0B0, 1'b0, 1'b1));
        do_pop(1'b0, 1'b1);
        chk_eq("byp.drain", 64'(count), 64'd0);
`else
        set_push(32'hA000, 64'hA1A1A1A1_A0A0A0A0, 2'b00);
        #1;
        chk_eq("nobyp.valid0", 64'(valid0), 64'd0);
        chk_eq("nobyp.valid1", 64'(valid1), 64'd0);
        step();
        idle_inputs();
        chk_head("nobyp.next", mk(32'hA000, 64'hA1A1A1A1_A0A0A0A0, 1'b1, 1'b1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
